fighter_controller: RTL and testbench
=====================================

# fighter_controller

Per-player motion and action state machine sitting directly upstream of the VGA pixel generator. Takes debounced buttons and a once-per-frame tick, advances an IDLE/WALK/JUMP/PUNCH/BLOCK/STUN machine, and produces the sprite top-left position and 7-bit action code consumed by the renderer. Outputs change only in vertical blank, so no frame ever shows a partial update. Instantiated twice, once per player.

## Interface
- START_X, 100, reset x position (top-left)
- GROUND_Y, 266, standing y (394 − 128)
- X_MIN, 0, leftmost legal x
- X_MAX, 512, rightmost legal x (640 − 128)
- FACE_RIGHT, 1, reset facing (1 = right)
- WALK_STEP, 4, px per frame while walking
- JUMP_V0, 12, initial upward speed, px/frame
- GRAVITY, 1, speed decrement per frame
- PUNCH_FRAMES, 12, punch duration in frames
- STUN_FRAMES, 20, stun duration in frames
- ANIM_DIV, 4, frames per animation step
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at vblank start (vCount = 480, hCount = 0)
- btn_left, btn_right, btn_up, btn_punch, btn_block  in  1 each  debounced, level, asynchronous to clk
- hit_in  in  1  one-cycle pulse from game logic: this player was struck
- opp_x  in  10  opponent sprite x
- pos_x, pos_y  out  10 each  sprite top-left
- action  out  7  [6] facing, [5:3] state code, [2:0] animation frame
- attack_active  out  1  one-cycle pulse on the punch hit frame
- blocking  out  1  high while in BLOCK

## Operation
- Buttons pass through a 2-flop synchroniser. btn_punch rising edge and hit_in set sticky flags. Each flag is cleared on the frame_tick that consumes it.
- All state, position and counter updates happen only on frame_tick. Priority order: hit > state rules.
- Any state, hit flag set: go to STUN, counter = STUN_FRAMES. An airborne player keeps the current vertical velocity.
- IDLE/WALK, checked in this order:
  - punch flag: go to PUNCH, counter = PUNCH_FRAMES.
  - up: go to JUMP, vel = JUMP_V0.
  - block: go to BLOCK.
  - exactly one of left/right: go to WALK, x ± WALK_STEP, facing updated.
  - otherwise: go to IDLE.
- BLOCK: stay while block is held; on release go to IDLE.
- PUNCH: counter decrements. attack_active pulses on the tick where counter reaches PUNCH_FRAMES/2. At 0, go to IDLE.
- JUMP: y −= vel, then vel −= GRAVITY. Left/right steers x. When y ≥ GROUND_Y: clamp y = GROUND_Y, go to IDLE.
- STUN: x frozen; gravity still applies. When the counter reaches 0 and y = GROUND_Y, go to IDLE.
- Arithmetic: x, y and vel are 11-bit signed internally. x is clamped to [X_MIN, X_MAX] after every step. y never exceeds GROUND_Y.
- Animation frame: increments every ANIM_DIV ticks, wraps 7→0, resets to 0 on any state change.
- State codes: IDLE 0, WALK 1, JUMP 2, PUNCH 3, BLOCK 4, STUN 5.

## Timing
- Outputs are registered and update on the clk cycle after frame_tick (1-cycle latency). They hold stable for the rest of the frame.
- Reset values: pos_x = START_X, pos_y = GROUND_Y, action = {FACE_RIGHT, 3'd0, 3'd0}, attack_active = 0, blocking = 0, sticky flags = 0, vel = 0.
- Reset asserted mid-jump or mid-punch returns all outputs to reset values immediately.
- Button edge and frame_tick on the same cycle: the edge is registered and consumed at the next tick.
- hit_in and frame_tick on the same cycle: the hit is consumed on the following tick.

## Configuration
- FIGHTER_COLLISION_EN defined: a WALK/JUMP x step that moves toward the opponent is cancelled if it would make |x − opp_x| < 128 (x holds its old value).
- Not defined: opp_x is ignored; only the X_MIN/X_MAX clamp applies.

## Structure
- fighter_pkg holds: state code localparams, action field bit positions, SPRITE_W = 128, SCREEN_W = 640.
- Sub-module fighter_input_latch: synchroniser, punch edge detect, sticky punch and hit flags, clear-on-tick.

## Test plan
- Reset, then 3 ticks with nothing pressed → pos = (100, 266), action = 7'b1_000_000.
- Hold right for 10 ticks from x = 100 → pos_x = 140, state WALK. Hold right further → pos_x saturates at 512.
- Up pressed at x = 100 → y sequence 254, 243, 233, …; lands at 266 on tick 25 with state IDLE. attack_active stays 0 throughout.
- Punch edge → PUNCH for 12 ticks; attack_active high exactly once, on the 6th tick; then IDLE.
- hit_in during BLOCK → STUN for 20 ticks, x unchanged, then IDLE. hit_in coincident with frame_tick → STUN entered one tick later.
- FIGHTER_COLLISION_EN, x = 300, opp_x = 430, hold right → x stops at 300 (next step would give distance 126 < 128). Same run without the macro → x reaches 512.

Source files
------------

// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared state codes, action field layout and screen geometry for the fighter
package fighter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WALK  = 3'd1,
        ST_JUMP  = 3'd2,
        ST_PUNCH = 3'd3,
        ST_BLOCK = 3'd4,
        ST_STUN  = 3'd5
    } fighter_state_e;

    localparam int ACT_FACE_BIT  = 6;
    localparam int ACT_STATE_LSB = 3;
    localparam int ACT_ANIM_LSB  = 0;
    localparam int SPRITE_W      = 128;
    localparam int SCREEN_W      = 640;

    function automatic logic signed [10:0] clamp_x(input logic signed [10:0] x,
                                                   input logic signed [10:0] lo,
                                                   input logic signed [10:0] hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/fighter_if.sv
// rtl/fighter_if.sv - player controls in, sprite position and action code out
interface fighter_if;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_punch;
    logic       btn_block;
    logic       hit_in;
    logic [9:0] opp_x;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [6:0] action;
    logic       attack_active;
    logic       blocking;

    modport master (
        output frame_tick, btn_left, btn_right, btn_up, btn_punch, btn_block, hit_in, opp_x,
        input  pos_x, pos_y, action, attack_active, blocking
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_up, btn_punch, btn_block, hit_in, opp_x,
        output pos_x, pos_y, action, attack_active, blocking
    );
endinterface

// File: rtl/fighter_input_latch.sv
// rtl/fighter_input_latch.sv - button synchroniser plus sticky punch/hit flags cleared by frame_tick
module fighter_input_latch (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_up,
    input  logic btn_punch,
    input  logic btn_block,
    input  logic hit_in,
    output logic left,
    output logic right,
    output logic up,
    output logic block,
    output logic punch_flag,
    output logic hit_flag
);

    logic [4:0] meta;
    logic [4:0] sync;
    logic       punch_prev;
    logic       punch_rise;

    assign punch_rise = sync[3] & ~punch_prev;

    // A new event arriving on the tick cycle wins over the clear, so it survives to the next tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta       <= '0;
            sync       <= '0;
            punch_prev <= 1'b0;
            punch_flag <= 1'b0;
            hit_flag   <= 1'b0;
        end else begin
            meta       <= {btn_block, btn_punch, btn_up, btn_right, btn_left};
            sync       <= meta;
            punch_prev <= sync[3];
            punch_flag <= punch_rise | (punch_flag & ~frame_tick);
            hit_flag   <= hit_in | (hit_flag & ~frame_tick);
        end
    end

    assign left  = sync[0];
    assign right = sync[1];
    assign up    = sync[2];
    assign block = sync[4];

endmodule

// File: rtl/fighter_controller.sv
// rtl/fighter_controller.sv - per-player motion/action FSM updated once per frame; FIGHTER_COLLISION_EN adds opponent blocking
module fighter_controller
    import fighter_pkg::*;
#(
    parameter int START_X      = 100,
    parameter int GROUND_Y     = 266,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 512,
    parameter int FACE_RIGHT   = 1,
    parameter int WALK_STEP    = 4,
    parameter int JUMP_V0      = 12,
    parameter int GRAVITY      = 1,
    parameter int PUNCH_FRAMES = 12,
    parameter int STUN_FRAMES  = 20,
    parameter int ANIM_DIV     = 4
) (
    input  logic     clk,
    input  logic     rst,
    fighter_if.slave bus
);

    localparam logic signed [10:0] GY   = 11'(GROUND_Y);
    localparam logic signed [10:0] XL   = 11'(X_MIN);
    localparam logic signed [10:0] XH   = 11'(X_MAX);
    localparam logic signed [10:0] STEP = 11'(WALK_STEP);
    localparam logic signed [10:0] V0   = 11'(JUMP_V0);
    localparam logic signed [10:0] G    = 11'(GRAVITY);

    logic left, right, up, block, punch_flag, hit_flag;

    fighter_input_latch u_latch (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (bus.frame_tick),
        .btn_left   (bus.btn_left),
        .btn_right  (bus.btn_right),
        .btn_up     (bus.btn_up),
        .btn_punch  (bus.btn_punch),
        .btn_block  (bus.btn_block),
        .hit_in     (bus.hit_in),
        .left       (left),
        .right      (right),
        .up         (up),
        .block      (block),
        .punch_flag (punch_flag),
        .hit_flag   (hit_flag)
    );

    fighter_state_e     state_q, state_n;
    logic signed [10:0] x_q, x_n, y_q, y_n, vel_q, vel_n, step_x, y_fall;
    logic [7:0]         cnt_q, cnt_n, div_q;
    logic [2:0]         anim_q;
    logic               facing_q, facing_n, step_face, attack_q, attack_n;

`ifdef FIGHTER_COLLISION_EN
    logic signed [10:0] opp, gap;
`else
    logic opp_unused;
    assign opp_unused = ^bus.opp_x;
`endif

    // Horizontal step a WALK or JUMP tick would take from the current buttons.
    always_comb begin
        step_x    = x_q;
        step_face = facing_q;
        if (right && !left) begin
            step_x    = clamp_x(x_q + STEP, XL, XH);
            step_face = 1'b1;
        end else if (left && !right) begin
            step_x    = clamp_x(x_q - STEP, XL, XH);
            step_face = 1'b0;
        end
`ifdef FIGHTER_COLLISION_EN
        opp = $signed({1'b0, bus.opp_x});
        gap = (step_x > opp) ? step_x - opp : opp - step_x;
        if (((step_x > x_q) && (opp > x_q)) || ((step_x < x_q) && (opp < x_q)))
            if (gap < 11'(SPRITE_W))
                step_x = x_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= 11'(START_X);
            y_q      <= GY;
            vel_q    <= '0;
            cnt_q    <= '0;
            facing_q <= 1'(FACE_RIGHT);
            anim_q   <= '0;
            div_q    <= '0;
            attack_q <= 1'b0;
        end else begin
            attack_q <= bus.frame_tick & attack_n;
            if (bus.frame_tick) begin
                state_q  <= state_n;
                x_q      <= x_n;
                y_q      <= y_n;
                vel_q    <= vel_n;
                cnt_q    <= cnt_n;
                facing_q <= facing_n;
                if (state_n != state_q) begin
                    anim_q <= '0;
                    div_q  <= '0;
                end else if (div_q == 8'(ANIM_DIV - 1)) begin
                    anim_q <= anim_q + 3'd1;
                    div_q  <= '0;
                end else begin
                    div_q <= div_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        state_n  = state_q;
        x_n      = x_q;
        y_n      = y_q;
        vel_n    = vel_q;
        cnt_n    = cnt_q;
        facing_n = facing_q;
        attack_n = 1'b0;
        y_fall   = y_q - vel_q;
        if (hit_flag) begin
            state_n = ST_STUN;
            cnt_n   = 8'(STUN_FRAMES);
        end else begin
            case (state_q)
                ST_IDLE, ST_WALK: begin
                    if (punch_flag) begin
                        state_n = ST_PUNCH;
                        cnt_n   = 8'(PUNCH_FRAMES);
                    end else if (up) begin
                        state_n = ST_JUMP;
                        y_n     = y_q - V0;
                        vel_n   = V0 - G;
                    end else if (block) begin
                        state_n = ST_BLOCK;
                    end else if (left ^ right) begin
                        state_n  = ST_WALK;
                        x_n      = step_x;
                        facing_n = step_face;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_JUMP: begin
                    x_n      = step_x;
                    facing_n = step_face;
                    y_n      = y_fall;
                    vel_n    = vel_q - G;
                    if (y_fall >= GY) begin
                        y_n     = GY;
                        vel_n   = '0;
                        state_n = ST_IDLE;
                    end
                end
                ST_PUNCH: begin
                    cnt_n    = cnt_q - 8'd1;
                    attack_n = (cnt_n == 8'(PUNCH_FRAMES / 2));
                    if (cnt_n == 8'd0)
                        state_n = ST_IDLE;
                end
                ST_BLOCK: begin
                    if (!block)
                        state_n = ST_IDLE;
                end
                ST_STUN: begin
                    // Only an airborne stun falls; a grounded one just counts down.
                    if (y_q < GY) begin
                        y_n   = y_fall;
                        vel_n = vel_q - G;
                        if (y_fall >= GY) begin
                            y_n   = GY;
                            vel_n = '0;
                        end
                    end
                    cnt_n = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
                    if (cnt_n == 8'd0 && y_n == GY)
                        state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.pos_x         = x_q[9:0];
        bus.pos_y         = y_q[9:0];
        bus.action        = {facing_q, state_q, anim_q};
        bus.attack_active = attack_q;
        bus.blocking      = (state_q == ST_BLOCK);
    end

endmodule

// File: tb/tb_fighter_controller.sv
// tb/tb_fighter_controller.sv - randomized frame-level bench against a behavioural fighter model
module tb_fighter_controller;

    localparam int GROUND  = 266;
    localparam int PUNCH_F = 12;
    localparam int STUN_F  = 20;
    localparam int JUMP_V  = 12;
    localparam int GRAV    = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fighter_if bus();

    fighter_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int m_state, m_x, m_y, m_vel, m_cnt, m_face, m_age;
    bit m_attack, exp_att, hit_carry, prev_p, chk_en, last_att;
    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    function automatic int exp_action();
        return m_face * 64 + m_state * 8 + ((m_age / 4) % 8);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pos_x", bus.pos_x, m_x);
            chk("pos_y", bus.pos_y, m_y);
            chk("action", bus.action, exp_action());
            chk("blocking", bus.blocking, (m_state == 4) ? 1 : 0);
            chk("attack_active", bus.attack_active, exp_att);
        end
    end

    task automatic model_reset();
        m_state = 0; m_x = 100; m_y = GROUND; m_vel = 0; m_cnt = 0; m_face = 1; m_age = 0;
        m_attack = 0; exp_att = 0; hit_carry = 0; prev_p = 0;
    endtask

    task automatic steer(input bit l, input bit r, input int opp);
        int nx;
        nx = m_x;
        if (r && !l) begin
            nx = (m_x + 4 > 512) ? 512 : m_x + 4;
            m_face = 1;
        end else if (l && !r) begin
            nx = (m_x - 4 < 0) ? 0 : m_x - 4;
            m_face = 0;
        end
`ifdef FIGHTER_COLLISION_EN
        if (nx != m_x && opp != m_x && ((nx > m_x) == (opp > m_x)))
            if (((nx > opp) ? nx - opp : opp - nx) < 128) nx = m_x;
`else
        if (opp < 0) nx = m_x;
`endif
        m_x = nx;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit u, input bit b,
                              input bit pf, input bit hf, input int opp);
        int ns;
        ns = m_state;
        m_attack = 0;
        if (hf) begin
            ns = 5; m_cnt = STUN_F;
        end else if (m_state <= 1) begin
            if (pf) begin ns = 3; m_cnt = PUNCH_F; end
            else if (u) begin ns = 2; m_y = m_y - JUMP_V; m_vel = JUMP_V - GRAV; end
            else if (b) ns = 4;
            else if (l != r) begin ns = 1; steer(l, r, opp); end
            else ns = 0;
        end else if (m_state == 2) begin
            steer(l, r, opp);
            m_y = m_y - m_vel; m_vel = m_vel - GRAV;
            if (m_y >= GROUND) begin m_y = GROUND; m_vel = 0; ns = 0; end
        end else if (m_state == 3) begin
            m_cnt--;
            m_attack = (m_cnt == PUNCH_F / 2);
            if (m_cnt == 0) ns = 0;
        end else if (m_state == 4) begin
            if (!b) ns = 0;
        end else begin
            if (m_y < GROUND) begin
                m_y = m_y - m_vel; m_vel = m_vel - GRAV;
                if (m_y >= GROUND) begin m_y = GROUND; m_vel = 0; end
            end
            if (m_cnt > 0) m_cnt--;
            if (m_cnt == 0 && m_y == GROUND) ns = 0;
        end
        m_age = (ns == m_state) ? m_age + 1 : 0;
        m_state = ns;
    endtask

    task automatic set_buttons(input bit l, input bit r, input bit u, input bit p, input bit b);
        bus.btn_left = l; bus.btn_right = r; bus.btn_up = u; bus.btn_punch = p; bus.btn_block = b;
    endtask

    // One frame: buttons held for 9 cycles, hit_in at cycle hit_at (7 = same cycle as frame_tick).
    task automatic frame(input bit l, input bit r, input bit u, input bit p, input bit b,
                         input int hit_at, input int opp);
        bit pf, hf;
        set_buttons(l, r, u, p, b);
        bus.opp_x = 10'(opp);
        pf = p && !prev_p;
        prev_p = p;
        for (int c = 0; c < 8; c++) begin
            bus.hit_in = (hit_at == c);
            bus.frame_tick = (c == 7);
            @(posedge clk); #1;
        end
        bus.hit_in = 1'b0;
        bus.frame_tick = 1'b0;
        hf = hit_carry || (hit_at >= 0 && hit_at < 7);
        hit_carry = (hit_at == 7);
        model_tick(l, r, u, b, pf, hf, opp);
        exp_att = m_attack;
        last_att = bus.attack_active;
        @(posedge clk); #1;
        exp_att = 0;
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) frame(0, 0, 0, 0, 0, -1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_buttons(0, 0, 0, 0, 0);
        bus.hit_in = 1'b0;
        bus.frame_tick = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int atts;
        set_buttons(0, 0, 0, 0, 0);
        bus.hit_in = 1'b0;
        bus.frame_tick = 1'b0;
        bus.opp_x = '0;
        model_reset();
        chk_en = 1'b1;
        @(posedge clk); #1;
        do_reset();
        chk("rst_pos_x", bus.pos_x, 100);
        chk("rst_pos_y", bus.pos_y, 266);
        chk("rst_action", bus.action, 64);
        idle_frames(3);
        chk("idle3_pos_x", bus.pos_x, 100);
        chk("idle3_action", bus.action, 64);

        for (int i = 0; i < 10; i++) frame(0, 1, 0, 0, 0, -1, 0);
        chk("walk10_x", bus.pos_x, 140);
        chk("walk10_state", bus.action[5:3], 1);
        for (int i = 0; i < 100; i++) frame(0, 1, 0, 0, 0, -1, 0);
        chk("walk_sat_x", bus.pos_x, 512);

        do_reset();
        frame(0, 0, 1, 0, 0, -1, 0);
        chk("jump_y1", bus.pos_y, 254);
        frame(0, 0, 0, 0, 0, -1, 0);
        chk("jump_y2", bus.pos_y, 243);
        frame(0, 0, 0, 0, 0, -1, 0);
        chk("jump_y3", bus.pos_y, 233);
        idle_frames(21);
        chk("jump_t24_state", bus.action[5:3], 2);
        idle_frames(1);
        chk("jump_land_y", bus.pos_y, 266);
        chk("jump_land_state", bus.action[5:3], 0);

        do_reset();
        frame(0, 0, 0, 1, 0, -1, 0);
        chk("punch_state", bus.action[5:3], 3);
        atts = 0;
        for (int k = 1; k <= 12; k++) begin
            frame(0, 0, 0, 0, 0, -1, 0);
            atts += int'(last_att);
            if (k == 6) chk("punch_att_tick6", last_att, 1);
            if (k == 11) chk("punch_t11_state", bus.action[5:3], 3);
        end
        chk("punch_att_count", atts, 1);
        chk("punch_end_state", bus.action[5:3], 0);

        do_reset();
        for (int i = 0; i < 5; i++) frame(0, 1, 0, 0, 0, -1, 0);
        frame(0, 0, 0, 0, 1, -1, 0);
        chk("block_flag", bus.blocking, 1);
        frame(0, 0, 0, 0, 1, 3, 0);
        chk("hit_stun", bus.action[5:3], 5);
        idle_frames(19);
        chk("stun_t19_state", bus.action[5:3], 5);
        chk("stun_x", bus.pos_x, 120);
        idle_frames(1);
        chk("stun_end_state", bus.action[5:3], 0);
        frame(0, 0, 0, 0, 1, -1, 0);
        frame(0, 0, 0, 0, 1, 7, 0);
        chk("hit_coinc_late", bus.action[5:3], 4);
        frame(0, 0, 0, 0, 1, -1, 0);
        chk("hit_coinc_stun", bus.action[5:3], 5);
        idle_frames(20);

        do_reset();
        for (int i = 0; i < 110; i++) frame(0, 1, 0, 0, 0, -1, 430);
`ifdef FIGHTER_COLLISION_EN
        chk("collide_x", bus.pos_x, 300);
`else
        chk("collide_x", bus.pos_x, 512);
`endif

        for (int i = 0; i < 500; i++) begin
            int hr, hit_at;
            if ($urandom_range(0, 99) < 2) do_reset();
            hr = $urandom_range(0, 99);
            hit_at = (hr < 5) ? $urandom_range(0, 6) : ((hr < 7) ? 7 : -1);
            frame($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 12, hit_at, $urandom_range(0, 639));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
